// File: rtl/hazard_ctrl_unit.sv
// ============================================================================
// hazard_ctrl_unit
// ----------------------------------------------------------------------------
// Hazard controller for the 5-stage (F/D/E/M/W) RISC-V pipeline.
//   * Operand forwarding selects for both E-stage operands (M beats W).
//   * Load-use stall: holds F/D and bubbles E for one cycle.
//   * Taken-branch flush: bubbles D and E for one cycle.
//   * Multi-cycle op (MUL/DIV) FSM: holds F/D/E and bubbles M for MC_LAT-1
//     cycles, starting combinationally in the cycle the op is first in E.
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   When defined, adds saturating performance counters StallCycles and
//   FlushEvents (CNT_W bits each).
//
// Parameters:
//   REG_AW  register address width (x0 is hard-zero, never forwarded)
//   MC_LAT  total cycles a multi-cycle op occupies E (>= 1)
//   CNT_W   performance counter width (HAZ_PERF_CNT_EN only)
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   RegWrite_M/W, Rd_M/W           writeback enable / destination in M, W
//   Rd_E, RS1_E, RS2_E             destination / sources in E
//   RS1_D, RS2_D                   sources in D
//   Load_E, PCSrc_E, MultiCycle_E  E-stage load / taken branch / multi-cycle
//   ForwardAE, ForwardBE           00 regfile, 10 from M, 01 from W
//   Stall_F/D/E                    hold pipeline register
//   Flush_D/E/M                    insert bubble
//   Busy                           FSM is in MC_BUSY (registered)
//   StallCycles, FlushEvents       perf counters (HAZ_PERF_CNT_EN only)
// ============================================================================
module hazard_ctrl_unit #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_M,
    input  logic              RegWrite_W,
    input  logic [REG_AW-1:0] Rd_M,
    input  logic [REG_AW-1:0] Rd_W,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic [REG_AW-1:0] RS1_E,
    input  logic [REG_AW-1:0] RS2_E,
    input  logic [REG_AW-1:0] RS1_D,
    input  logic [REG_AW-1:0] RS2_D,
    input  logic              Load_E,
    input  logic              PCSrc_E,
    input  logic              MultiCycle_E,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Stall_E,
    output logic              Flush_D,
    output logic              Flush_E,
    output logic              Flush_M,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0]  StallCycles,
    output logic [CNT_W-1:0]  FlushEvents,
`endif
    output logic              Busy
);

    localparam int CW = $clog2(MC_LAT) + 1;
    // Cycles spent in MC_BUSY while still stalling; unused when MC_LAT == 1.
    localparam logic [CW-1:0] CNT_INIT = (MC_LAT > 1) ? CW'(MC_LAT - 2) : '0;

    typedef enum logic {IDLE, MC_BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic idle;
    logic mc_start;
    logic mc_stall;
    logic branch;
    logic load_use;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign Busy = (state == MC_BUSY);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mc_start) begin
                    state_nxt = MC_BUSY;
                    cnt_nxt   = CNT_INIT;
                end
            end
            MC_BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (RegWrite_M && (Rd_M != '0) && (Rd_M == rs))
            return 2'b10;
        else if (RegWrite_W && (Rd_W != '0) && (Rd_W == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        idle     = (state == IDLE);
        // The start cycle stalls before the FSM has left IDLE.
        mc_start = idle && MultiCycle_E && (MC_LAT > 1);
        mc_stall = mc_start || (Busy && (cnt != '0));
        // A multi-cycle op in E masks branch and load-use, even when
        // MC_LAT == 1 and no stall is raised.
        branch   = idle && !MultiCycle_E && PCSrc_E;
        load_use = idle && !MultiCycle_E && !PCSrc_E && Load_E &&
                   (Rd_E != '0) && ((Rd_E == RS1_D) || (Rd_E == RS2_D));

        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        Stall_F   = 1'b0;
        Stall_D   = 1'b0;
        Stall_E   = 1'b0;
        Flush_D   = 1'b0;
        Flush_E   = 1'b0;
        Flush_M   = 1'b0;
        // Reset gates every combinational output, so an abort mid-stall
        // leaves no residual pulse.
        if (!rst) begin
            ForwardAE = fwd_sel(RS1_E);
            ForwardBE = fwd_sel(RS2_E);
            Stall_F   = mc_stall || load_use;
            Stall_D   = mc_stall || load_use;
            Stall_E   = mc_stall;
            Flush_D   = branch;
            Flush_E   = branch || load_use;
            Flush_M   = mc_stall;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCycles <= '0;
            FlushEvents <= '0;
        end else begin
            if (Stall_F && (StallCycles != '1))
                StallCycles <= StallCycles + CNT_W'(1);
            if ((Flush_D || Flush_E) && (FlushEvents != '1))
                FlushEvents <= FlushEvents + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ============================================================================
// tb_hazard_ctrl_unit
// ----------------------------------------------------------------------------
// Self-checking bench for hazard_ctrl_unit. Directed scenarios followed by
// randomized stimulus, all compared against a behavioural model that tracks
// how many more cycles the multi-cycle op will hold the controller busy.
// A second instance with MC_LAT = 1 checks the no-stall boundary.
// ============================================================================
module tb_hazard_ctrl_unit;

    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          RegWrite_M, RegWrite_W;
    logic [AW-1:0] Rd_M, Rd_W, Rd_E, RS1_E, RS2_E, RS1_D, RS2_D;
    logic          Load_E, PCSrc_E, MultiCycle_E;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, Busy;
    logic [1:0]    l1_fa, l1_fb;
    logic          l1_sf, l1_sd, l1_se, l1_fd, l1_fe, l1_fm, l1_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0] StallCycles, FlushEvents, l1_sc, l1_fc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_rem     = 0;  // busy cycles still to come, including current
    int m_stalls  = 0;
    int m_flushes = 0;
    int max_cnt   = (1 << CW) - 1;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(AW), .MC_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Rd_M(Rd_M), .Rd_W(Rd_W), .Rd_E(Rd_E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RS1_D(RS1_D), .RS2_D(RS2_D),
        .Load_E(Load_E), .PCSrc_E(PCSrc_E), .MultiCycle_E(MultiCycle_E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M),
`ifdef HAZ_PERF_CNT_EN
        .StallCycles(StallCycles), .FlushEvents(FlushEvents),
`endif
        .Busy(Busy)
    );

    hazard_ctrl_unit #(.REG_AW(AW), .MC_LAT(1), .CNT_W(CW)) dut_lat1 (
        .clk(clk), .rst(rst),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Rd_M(Rd_M), .Rd_W(Rd_W), .Rd_E(Rd_E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RS1_D(RS1_D), .RS2_D(RS2_D),
        .Load_E(Load_E), .PCSrc_E(PCSrc_E), .MultiCycle_E(MultiCycle_E),
        .ForwardAE(l1_fa), .ForwardBE(l1_fb),
        .Stall_F(l1_sf), .Stall_D(l1_sd), .Stall_E(l1_se),
        .Flush_D(l1_fd), .Flush_E(l1_fe), .Flush_M(l1_fm),
`ifdef HAZ_PERF_CNT_EN
        .StallCycles(l1_sc), .FlushEvents(l1_fc),
`endif
        .Busy(l1_busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
        if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
        if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        RegWrite_M = 0; RegWrite_W = 0;
        Rd_M = 0; Rd_W = 0; Rd_E = 0;
        RS1_E = 0; RS2_E = 0; RS1_D = 0; RS2_D = 0;
        Load_E = 0; PCSrc_E = 0; MultiCycle_E = 0;
    endtask

    // Entered just after a rising edge with inputs already driven: checks
    // at the falling edge, advances the model, then returns after the next
    // rising edge.
    task automatic cycle();
        bit busy, mc, br, lu;
        @(negedge clk);
        busy = (m_rem > 0);
        mc   = busy ? (m_rem > 1) : (MultiCycle_E && LAT > 1);
        br   = !busy && !MultiCycle_E && PCSrc_E;
        lu   = !busy && !MultiCycle_E && !PCSrc_E && Load_E && Rd_E != 0 &&
               (Rd_E == RS1_D || Rd_E == RS2_D);
        check("fwd_a",   ForwardAE, ref_fwd(RS1_E));
        check("fwd_b",   ForwardBE, ref_fwd(RS2_E));
        check("stall_f", Stall_F, mc || lu);
        check("stall_d", Stall_D, mc || lu);
        check("stall_e", Stall_E, mc);
        check("flush_d", Flush_D, br);
        check("flush_e", Flush_E, br || lu);
        check("flush_m", Flush_M, mc);
        check("busy",    Busy,    busy);
        if (MultiCycle_E) begin
            check("lat1_stall", {l1_sf, l1_se, l1_fm}, 3'b000);
            check("lat1_flush", {l1_fd, l1_fe},        2'b00);
            check("lat1_busy",  l1_busy,               1'b0);
        end
`ifdef HAZ_PERF_CNT_EN
        check("stall_cycles", StallCycles, m_stalls);
        check("flush_events", FlushEvents, m_flushes);
`endif
        if (busy) m_rem--;
        else if (MultiCycle_E && LAT > 1) m_rem = LAT - 1;
        if ((mc || lu) && m_stalls < max_cnt) m_stalls++;
        if ((br || lu) && m_flushes < max_cnt) m_flushes++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #3;
        // Reset state, forward selects forced to 00 even with a match present
        RegWrite_M = 1; Rd_M = 5; RS1_E = 5; Load_E = 1; Rd_E = 5; RS1_D = 5;
        MultiCycle_E = 1;
        #1;
        check("rst_fwd_a", ForwardAE, 2'b00);
        check("rst_stall", {Stall_F, Stall_D, Stall_E}, 3'b000);
        check("rst_flush", {Flush_D, Flush_E, Flush_M}, 3'b000);
        check("rst_busy",  Busy, 1'b0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Forwarding: M beats W, then W only
        RegWrite_M = 1; Rd_M = 5; RegWrite_W = 1; Rd_W = 5; RS1_E = 5; RS2_E = 0;
        #1;
        check("fwd_m_over_w", ForwardAE, 2'b10);
        check("fwd_rs0",      ForwardBE, 2'b00);
        cycle();
        Rd_M = 7;
        #1;
        check("fwd_w", ForwardAE, 2'b01);
        cycle();
        clear_inputs();

        // Load-use, then destination x0
        Load_E = 1; Rd_E = 3; RS2_D = 3;
        #1;
        check("lu_stall", {Stall_F, Stall_D, Flush_E}, 3'b111);
        cycle();
        Load_E = 0;
        cycle();
        Load_E = 1; Rd_E = 0; RS2_D = 0;
        #1;
        check("lu_x0", {Stall_F, Stall_D, Flush_E}, 3'b000);
        cycle();

        // Branch with simultaneous load-use: flush wins, no stall
        Load_E = 1; Rd_E = 3; RS2_D = 3; PCSrc_E = 1;
        #1;
        check("br_flush",   {Flush_D, Flush_E}, 2'b11);
        check("br_nostall", Stall_F, 1'b0);
        cycle();
        clear_inputs();

        // Multi-cycle op held: stalls in three cycles, busy the three after
        // the first; branch ignored while busy
        MultiCycle_E = 1;
        for (int k = 0; k < 4; k++) begin
            PCSrc_E = (k > 0);
            #1;
            check("mc_stall",   {Stall_F, Stall_D, Stall_E, Flush_M},
                  (k < 3) ? 4'hF : 4'h0);
            check("mc_busy",    Busy, k > 0);
            check("mc_nobr",    Flush_D, (k == 0) ? 1'b0 : 1'b0 | (k == 0));
            cycle();
        end
        clear_inputs();
        #1;
        check("mc_idle", Busy, 1'b0);
        cycle();

        // Back-to-back multi-cycle ops
        MultiCycle_E = 1;
        for (int k = 0; k < 8; k++) cycle();
        MultiCycle_E = 0;
        for (int k = 0; k < 4; k++) cycle();

        // Reset in the second cycle of a multi-cycle sequence
        MultiCycle_E = 1;
        cycle();
        RegWrite_M = 1; Rd_M = 9; RS2_E = 9;
        rst = 1'b1;
        #1;
        check("rst_mid_stall", {Stall_F, Stall_D, Stall_E, Flush_M}, 4'h0);
        check("rst_mid_busy",  Busy, 1'b0);
        check("rst_mid_fwd",   ForwardBE, 2'b00);
        m_rem = 0; m_stalls = 0; m_flushes = 0;
        #1;
        rst = 1'b0;
        clear_inputs();
        for (int k = 0; k < 3; k++) cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            RegWrite_M   = 1'($urandom_range(0, 1));
            RegWrite_W   = 1'($urandom_range(0, 1));
            Rd_M         = AW'($urandom_range(0, 7));
            Rd_W         = AW'($urandom_range(0, 7));
            Rd_E         = AW'($urandom_range(0, 7));
            RS1_E        = AW'($urandom_range(0, 7));
            RS2_E        = AW'($urandom_range(0, 7));
            RS1_D        = AW'($urandom_range(0, 7));
            RS2_D        = AW'($urandom_range(0, 7));
            Load_E       = ($urandom_range(0, 2) == 0);
            PCSrc_E      = ($urandom_range(0, 4) == 0);
            MultiCycle_E = ($urandom_range(0, 5) == 0);
            cycle();
        end

`ifdef HAZ_PERF_CNT_EN
        // Saturation: many stall cycles drive StallCycles to all-ones
        clear_inputs();
        MultiCycle_E = 1;
        for (int k = 0; k < 28; k++) cycle();
        check("stall_sat", StallCycles, 4'hF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Next-generation hazard controller for the 5-stage pipelined RISC-V core (F/D/E/M/W); replaces the purely combinational forwarding unit.
- Forwarding mux selects for both E-stage operands, width-parametrised on register address.
- Load-use stall, taken-branch flush, and a sequential multi-cycle-op stall FSM (MUL/DIV latency) that holds F/D/E and bubbles M.

Parameters:
- REG_AW, 5, register address width (x0 always hard-zero).
- MC_LAT, 4, total cycles a multi-cycle op occupies E; must be >= 1.
- CNT_W, 16, perf counter width (used only with HAZ_PERF_CNT_EN).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- RegWrite_M, RegWrite_W  in  1  writeback enables in M and W
- Rd_M, Rd_W, Rd_E  in  REG_AW  destination regs in M, W, E
- RS1_E, RS2_E  in  REG_AW  source regs in E
- RS1_D, RS2_D  in  REG_AW  source regs in D
- Load_E  in  1  instruction in E is a load
- PCSrc_E  in  1  branch/jump taken, resolved in E
- MultiCycle_E  in  1  instruction in E is a multi-cycle op
- ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W
- Stall_F, Stall_D, Stall_E  out  1  hold the pipeline register
- Flush_D, Flush_E, Flush_M  out  1  insert a bubble
- Busy  out  1  FSM in MC_BUSY

Behaviour:
- Reset (async, immediate): state IDLE, cnt 0. All stalls, flushes, Busy 0. Forward outputs forced 00 while rst high. Reset mid-MC_BUSY aborts the stall with no residual pulse.
- Forwarding (combinational) per operand:
  - 10 if RegWrite_M & Rd_M!=0 & Rd_M==RS
  - else 01 if RegWrite_W & Rd_W!=0 & Rd_W==RS
  - else 00
  - M beats W. Forwarding stays active during stalls.
- Load-use (combinational, IDLE only, MultiCycle_E=0, PCSrc_E=0): Load_E & Rd_E!=0 & (Rd_E==RS1_D | Rd_E==RS2_D) -> Stall_F=Stall_D=Flush_E=1 for one cycle.
- Branch (IDLE only, MultiCycle_E=0): PCSrc_E -> Flush_D=Flush_E=1 for one cycle. It suppresses load-use stall in the same cycle.
- Multi-cycle FSM, states IDLE and MC_BUSY, cnt width clog2(MC_LAT)+1:
  - Op first seen in E at cycle t, IDLE & MultiCycle_E & MC_LAT>1: Stall_F/D/E=1 and Flush_M=1 combinationally in cycle t. Next state MC_BUSY, cnt<=MC_LAT-2.
  - In MC_BUSY: stalls and Flush_M asserted while cnt!=0, and cnt decrements. At cnt==0 no stall is asserted and next state is IDLE.
  - Net effect: stall in cycles t..t+MC_LAT-2 (MC_LAT-1 cycles); op leaves E after cycle t+MC_LAT-1.
  - MultiCycle_E, Load_E and PCSrc_E are ignored while Busy. Stall asserted in IDLE on the MultiCycle_E cycle suppresses load-use and branch outputs.
  - MC_LAT==1: no stall, FSM stays IDLE.
  - A back-to-back multi-cycle op entering E in the cycle after return to IDLE restarts the sequence.
- Outputs other than Busy are combinational from state, cnt and inputs. Busy is registered state.

Optional Feature:
- HAZ_PERF_CNT_EN defined: adds outputs StallCycles and FlushEvents (CNT_W each), with async reset to 0 and saturation at all-ones.
  - StallCycles += 1 each cycle Stall_F=1.
  - FlushEvents += 1 each cycle Flush_D|Flush_E=1.
- Not defined: no counters, no extra ports, identical other behaviour.

Test Plan:
- RegWrite_M=1, Rd_M=5, RegWrite_W=1, Rd_W=5, RS1_E=5, RS2_E=0 -> ForwardAE=10, ForwardBE=00. Then Rd_M=7 -> ForwardAE=01.
- Load_E=1, Rd_E=3, RS2_D=3 -> one cycle Stall_F=Stall_D=Flush_E=1. Rd_E=0 -> no stall.
- MC_LAT=4, MultiCycle_E=1 at cycle 10 (held) -> Stall_F/D/E and Flush_M high cycles 10-12, low cycle 13. Busy high cycles 11-13, IDLE at 14.
- PCSrc_E=1 with load-use condition also true -> Flush_D=Flush_E=1, Stall_F=0. During Busy, PCSrc_E=1 -> no flush.
- rst asserted at cycle 11 of multi-cycle sequence -> all stalls and Busy 0 immediately. After release with MultiCycle_E=0, remains IDLE.
- HAZ_PERF_CNT_EN, CNT_W=4: 20 stall cycles -> StallCycles saturates at 15.
